// File: rtl/cache_mem_if.sv
// Cache <-> memory responder bus: read request, read return burst and write request.
interface cache_mem_if;
    logic         rd_req;
    logic [2:0]   rd_type;
    logic [31:0]  rd_addr;
    logic         rd_rdy;
    logic         ret_valid;
    logic         ret_last;
    logic [31:0]  ret_data;
    logic         wr_req;
    logic [2:0]   wr_type;
    logic [31:0]  wr_addr;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;
    logic         wr_rdy;

    modport master (
        output rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
        input  rd_rdy, ret_valid, ret_last, ret_data, wr_rdy
    );
    modport slave (
        input  rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
        output rd_rdy, ret_valid, ret_last, ret_data, wr_rdy
    );
endinterface

// File: rtl/cache_mem_responder.sv
// Word-organised RAM behind the cache: fixed-latency read bursts, single-edge
// line/word writes with a programmable busy window.
module cache_mem_responder #(
    parameter int    ADDR_WIDTH = 12,
    parameter int    RD_LATENCY = 2,
    parameter int    WR_LATENCY = 1,
    parameter string INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        resetn,
    cache_mem_if.slave  bus
);
    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [2:0] TYPE_LINE = 3'b100;
    localparam logic [3:0] RD_LAT_M1 = 4'(RD_LATENCY - 1);
    localparam logic [3:0] WR_LAT_M1 = 4'(WR_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_BURST, WR_BUSY} state_t;

    state_t                  state, state_nxt;
    logic [3:0]              lat_cnt, lat_cnt_nxt;
    logic [1:0]              beat, beat_nxt;
    logic                    is_line, is_line_nxt;
    logic [ADDR_WIDTH-1:0]   rd_word, rd_word_nxt;
    logic [ADDR_WIDTH-1:0]   beat_addr;
    logic                    rd_fire, wr_fire, burst_done;
    logic [31:0]             mem [DEPTH];

    // Writes win over reads so a victim writeback lands before its refill.
    assign bus.wr_rdy    = resetn && (state == IDLE);
    assign bus.rd_rdy    = resetn && (state == IDLE) && !bus.wr_req;
    assign rd_fire       = bus.rd_req && bus.rd_rdy;
    assign wr_fire       = bus.wr_req && bus.wr_rdy;

    assign burst_done    = !is_line || (beat == 2'd3);
    assign beat_addr     = is_line ? {rd_word[ADDR_WIDTH-1:2], beat} : rd_word;
    assign bus.ret_valid = resetn && (state == RD_BURST);
    assign bus.ret_last  = bus.ret_valid && burst_done;
    assign bus.ret_data  = bus.ret_valid ? mem[beat_addr] : '0;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            lat_cnt <= '0;
            beat    <= '0;
            is_line <= 1'b0;
            rd_word <= '0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= lat_cnt_nxt;
            beat    <= beat_nxt;
            is_line <= is_line_nxt;
            rd_word <= rd_word_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        lat_cnt_nxt = lat_cnt;
        beat_nxt    = beat;
        is_line_nxt = is_line;
        rd_word_nxt = rd_word;
        case (state)
            IDLE: begin
                if (wr_fire) begin
                    if (WR_LATENCY != 0) begin
                        state_nxt   = WR_BUSY;
                        lat_cnt_nxt = WR_LAT_M1;
                    end
                end else if (rd_fire) begin
                    is_line_nxt = (bus.rd_type == TYPE_LINE);
                    rd_word_nxt = bus.rd_addr[ADDR_WIDTH+1:2];
                    beat_nxt    = 2'd0;
                    lat_cnt_nxt = RD_LAT_M1;
                    state_nxt   = (RD_LATENCY == 1) ? RD_BURST : RD_WAIT;
                end
            end
            RD_WAIT: begin
                lat_cnt_nxt = lat_cnt - 4'd1;
                if (lat_cnt == 4'd1) state_nxt = RD_BURST;
            end
            RD_BURST: begin
                beat_nxt = beat + 2'd1;
                if (burst_done) begin
                    state_nxt = IDLE;
                    beat_nxt  = 2'd0;
                end
            end
            WR_BUSY: begin
                if (lat_cnt == 4'd0) state_nxt = IDLE;
                else                 lat_cnt_nxt = lat_cnt - 4'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Memory has no reset; wr_rdy already masks writes while resetn is low.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            if (bus.wr_type == TYPE_LINE) begin
                for (int i = 0; i < 4; i++)
                    mem[{bus.wr_addr[ADDR_WIDTH+1:4], 2'(i)}] <= bus.wr_data[32*i +: 32];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (bus.wr_wstrb[b])
                        mem[bus.wr_addr[ADDR_WIDTH+1:2]][8*b +: 8] <= bus.wr_data[8*b +: 8];
            end
        end
    end

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.rd_addr[31:ADDR_WIDTH+2], bus.rd_addr[1:0],
                                bus.wr_addr[31:ADDR_WIDTH+2], bus.wr_addr[1:0]};
endmodule
